// File: rtl/mem_arb_if.sv
// Arbiter bus bundle: instruction port, data port and shared memory bus.
// slave = the arbiter's view, master = the clients/memory driving it.
interface mem_arb_if #(
    parameter int RW     = 16,
    parameter int I_SIZE = 32
);
    logic              i_ins_req;
    logic [RW-1:0]     i_ins_addr;
    logic [I_SIZE-1:0] o_ins_data;
    logic              o_ins_valid;
    logic              i_ins_flush;

    logic              i_d_req;
    logic              i_d_we;
    logic [RW-1:0]     i_d_addr;
    logic [RW-1:0]     i_d_wdata;
    logic [RW-1:0]     o_d_rdata;
    logic              o_d_ack;

    logic              o_mem_req;
    logic              o_mem_we;
    logic [RW-1:0]     o_mem_addr;
    logic [RW-1:0]     o_mem_wdata;
    logic              o_mem_ins;
    logic              i_mem_ack;
    logic [I_SIZE-1:0] i_mem_rdata;

    modport slave (
        input  i_ins_req, i_ins_addr, i_ins_flush,
        input  i_d_req, i_d_we, i_d_addr, i_d_wdata,
        input  i_mem_ack, i_mem_rdata,
        output o_ins_data, o_ins_valid, o_d_rdata, o_d_ack,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_ins
    );

    modport master (
        output i_ins_req, i_ins_addr, i_ins_flush,
        output i_d_req, i_d_we, i_d_addr, i_d_wdata,
        output i_mem_ack, i_mem_rdata,
        input  o_ins_data, o_ins_valid, o_d_rdata, o_d_ack,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_ins
    );
endinterface

// File: rtl/mem_arb.sv
// Two-port (instruction/data) arbiter onto a single memory bus.
// MEM_ARB_RR_EN defined: round-robin grant; undefined: data port has fixed priority.
module mem_arb #(
    parameter int RW     = 16,
    parameter int I_SIZE = 32
) (
    input  logic      i_clk,
    input  logic      i_rst,
    mem_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, INS_BUS, DAT_BUS, DONE} state_e;

    state_e            state_q, state_d;
    logic              is_ins_q, is_ins_d;
    logic              we_q, we_d;
    logic [RW-1:0]     addr_q, addr_d;
    logic [RW-1:0]     wdata_q, wdata_d;
    logic              flushed_q, flushed_d;
    logic [I_SIZE-1:0] ins_data_q, ins_data_d;
    logic [RW-1:0]     d_rdata_q, d_rdata_d;
    logic              grant_ins;

`ifdef MEM_ARB_RR_EN
    logic              last_ins_q, last_ins_d;

    // On contention, hand the bus to whichever port did not win last time.
    assign grant_ins = bus.i_ins_req && (!bus.i_d_req || !last_ins_q);
`else
    assign grant_ins = bus.i_ins_req && !bus.i_d_req;
`endif

    always_comb begin
        state_d    = state_q;
        is_ins_d   = is_ins_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        flushed_d  = flushed_q;
        ins_data_d = ins_data_q;
        d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_ins_d = last_ins_q;
`endif
        case (state_q)
            IDLE: begin
                flushed_d = 1'b0;
                if (bus.i_ins_req || bus.i_d_req) begin
                    is_ins_d = grant_ins;
`ifdef MEM_ARB_RR_EN
                    last_ins_d = grant_ins;
`endif
                    if (grant_ins) begin
                        addr_d  = bus.i_ins_addr;
                        we_d    = 1'b0;
                        state_d = INS_BUS;
                    end else begin
                        addr_d  = bus.i_d_addr;
                        we_d    = bus.i_d_we;
                        wdata_d = bus.i_d_wdata;
                        state_d = DAT_BUS;
                    end
                end
            end
            INS_BUS: begin
                // A flush seen at any point of the cycle kills the eventual pulse.
                flushed_d = flushed_q || bus.i_ins_flush;
                if (bus.i_mem_ack) begin
                    ins_data_d = bus.i_mem_rdata;
                    state_d    = DONE;
                end
            end
            DAT_BUS: begin
                if (bus.i_mem_ack) begin
                    if (!we_q) d_rdata_d = bus.i_mem_rdata[RW-1:0];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            is_ins_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            flushed_q  <= 1'b0;
            ins_data_q <= '0;
            d_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
            last_ins_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            is_ins_q   <= is_ins_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            flushed_q  <= flushed_d;
            ins_data_q <= ins_data_d;
            d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_ins_q <= last_ins_d;
`endif
        end
    end

    assign bus.o_mem_req   = (state_q == INS_BUS) || (state_q == DAT_BUS);
    assign bus.o_mem_ins   = (state_q == INS_BUS);
    assign bus.o_mem_we    = (state_q == DAT_BUS) && we_q;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;
    assign bus.o_ins_data  = ins_data_q;
    assign bus.o_d_rdata   = d_rdata_q;
    assign bus.o_ins_valid = (state_q == DONE) && is_ins_q && !flushed_q && !bus.i_ins_flush;
    assign bus.o_d_ack     = (state_q == DONE) && !is_ins_q;
endmodule
